// File: rtl/fetch_pkg.sv
// Shared definitions for the IF stage: PC source encodings, FSM states,
// default bubble word and a word-alignment helper.
package fetch_pkg;

    // id_if_selpctype encodings
    localparam logic [1:0] PCTYPE_BRANCH = 2'b00;
    localparam logic [1:0] PCTYPE_JUMP   = 2'b01;
    localparam logic [1:0] PCTYPE_REG    = 2'b10;
    localparam logic [1:0] PCTYPE_EXC    = 2'b11;

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

    // sll r0,r0,0
    localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

    // Force an address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_mux.sv
// Next-PC selection: picks the redirect target by type, word-aligns it,
// then prioritises live redirect over a pending one over sequential pc+4.
module fetch_pc_mux
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        redirect,
    input  logic        pend,
    input  logic [1:0]  selpctype,
    input  logic [31:0] pcimd2ext,
    input  logic [31:0] pcindex,
    input  logic [31:0] rega,
    input  logic [31:0] pend_tgt,
    input  logic [31:0] pc,
    output logic [31:0] target,
    output logic [31:0] npc
);

    logic [31:0] raw_tgt;

    // Target select and npc priority
    always_comb begin
        raw_tgt = pcimd2ext;
        case (selpctype)
            PCTYPE_BRANCH: raw_tgt = pcimd2ext;
            PCTYPE_JUMP:   raw_tgt = pcindex;
            PCTYPE_REG:    raw_tgt = rega;
            PCTYPE_EXC:    raw_tgt = EXC_VECTOR;
        endcase
        target = word_align(raw_tgt);
        if (redirect)
            npc = target;
        else if (pend)
            npc = pend_tgt;
        else
            npc = pc + 32'd4;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, issues imem reads,
// feeds ID with one branch-delay slot and inserts bubbles on imem wait.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP,
    parameter int          CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    output logic [31:0]      imem_addr,
    output logic             imem_read,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    input  logic             if_stall,
    input  logic             id_if_selpcsource,
    input  logic [1:0]       id_if_selpctype,
    input  logic [31:0]      id_if_pcimd2ext,
    input  logic [31:0]      id_if_pcindex,
    input  logic [31:0]      id_if_rega,
    output logic [31:0]      if_id_instruc,
    output logic [31:0]      if_id_nextpc,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] if_perf_bubbles,
    output logic [CNT_W-1:0] if_perf_redirects
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pend_q, pend_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;
    logic [31:0]  hold_buf_q, hold_buf_d;
    logic [31:0]  instruc_q, instruc_d;
    logic [31:0]  nextpc_q, nextpc_d;
    logic         valid_q, valid_d;

    logic         in_fetch, in_hold, accept, bubble, redirect_live;
    logic [31:0]  word, target, npc;

    // Handshake decode; a redirect only counts while ID holds a real instruction
    always_comb begin
        in_fetch      = (state_q == S_FETCH);
        in_hold       = (state_q == S_HOLD);
        accept        = ~if_stall & ((in_fetch & imem_ready) | in_hold);
        bubble        = in_fetch & ~imem_ready & ~if_stall;
        redirect_live = id_if_selpcsource & valid_q;
        word          = in_hold ? hold_buf_q : imem_rdata;
    end

    fetch_pc_mux #(.EXC_VECTOR(EXC_VECTOR)) u_pc_mux (
        .redirect  (redirect_live),
        .pend      (pend_q),
        .selpctype (id_if_selpctype),
        .pcimd2ext (id_if_pcimd2ext),
        .pcindex   (id_if_pcindex),
        .rega      (id_if_rega),
        .pend_tgt  (pend_tgt_q),
        .pc        (pc_q),
        .target    (target),
        .npc       (npc)
    );

    // FSM next state, PC update and IF/ID register load
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        hold_buf_d = hold_buf_q;
        instruc_d  = instruc_q;
        nextpc_d   = nextpc_q;
        valid_d    = valid_q;

        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                // Word arrived while ID is frozen: park it until the stall lifts
                if (imem_ready && if_stall) begin
                    state_d    = S_HOLD;
                    hold_buf_d = imem_rdata;
                end
            end
            S_HOLD:  if (!if_stall) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            instruc_d = word;
            nextpc_d  = pc_q + 32'd4;
            valid_d   = 1'b1;
            pc_d      = npc;
            pend_d    = 1'b0;
        end else begin
            // Redirect with no slot accepted yet: remember it for the slot
            if (redirect_live) begin
                pend_d     = 1'b1;
                pend_tgt_d = target;
            end
            if (bubble) begin
                instruc_d = NOP_INSTR;
                valid_d   = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            hold_buf_q <= NOP_INSTR;
            instruc_q  <= NOP_INSTR;
            nextpc_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            hold_buf_q <= hold_buf_d;
            instruc_q  <= instruc_d;
            nextpc_q   <= nextpc_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_read     = in_fetch;
    assign imem_addr     = pc_q;
    assign if_id_instruc = instruc_q;
    assign if_id_nextpc  = nextpc_q;
    assign if_id_valid   = valid_q;

`ifdef FETCH_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] bub_q, bub_d, redir_q, redir_d;
    logic             took_tgt;

    // Saturating bubble / redirect counters
    always_comb begin
        bub_d    = bub_q;
        redir_d  = redir_q;
        took_tgt = accept & (redirect_live | pend_q);
        if (bubble && !(&bub_q))
            bub_d = bub_q + CNT_ONE;
        if (took_tgt && !(&redir_q))
            redir_d = redir_q + CNT_ONE;
    end

    // Counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bub_q   <= '0;
            redir_q <= '0;
        end else begin
            bub_q   <= bub_d;
            redir_q <= redir_d;
        end
    end

    assign if_perf_bubbles   = bub_q;
    assign if_perf_redirects = redir_q;
`else
    assign if_perf_bubbles   = '0;
    assign if_perf_redirects = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_stall = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  seltype = 2'b00;
    logic [31:0] pcimd2ext = 32'h0;
    logic [31:0] pcindex = 32'h0;
    logic [31:0] rega = 32'h0;
    logic [31:0] if_id_instruc;
    logic [31:0] if_id_nextpc;
    logic        if_id_valid;
    logic [31:0] perf_bub;
    logic [31:0] perf_redir;

    int tests = 0;
    int fails = 0;

    // Reference model state (what ID should see, where IF should be fetching)
    bit          m_started, m_held, m_pend, m_valid;
    logic [31:0] m_pc, m_pend_tgt, m_held_word, m_instr, m_nextpc;
    logic [31:0] m_bub, m_redir;

    fetch_stage dut (
        .clock             (clock),
        .reset             (reset),
        .imem_addr         (imem_addr),
        .imem_read         (imem_read),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .if_stall          (if_stall),
        .id_if_selpcsource (sel),
        .id_if_selpctype   (seltype),
        .id_if_pcimd2ext   (pcimd2ext),
        .id_if_pcindex     (pcindex),
        .id_if_rega        (rega),
        .if_id_instruc     (if_id_instruc),
        .if_id_nextpc      (if_id_nextpc),
        .if_id_valid       (if_id_valid),
        .if_perf_bubbles   (perf_bub),
        .if_perf_redirects (perf_redir)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pick_target(input logic [1:0] t);
        logic [31:0] r;
        case (t)
            2'b00:   r = pcimd2ext;
            2'b01:   r = pcindex;
            2'b10:   r = rega;
            default: r = 32'h8000_0180;
        endcase
        return r & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] exp_bub();
`ifdef FETCH_PERF_EN
        return m_bub;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] exp_redir();
`ifdef FETCH_PERF_EN
        return m_redir;
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_reset();
        m_started = 0; m_held = 0; m_pend = 0; m_valid = 0;
        m_pc = 0; m_pend_tgt = 0; m_held_word = 0; m_instr = 0; m_nextpc = 0;
        m_bub = 0; m_redir = 0;
    endtask

    // One clock of the pipeline contract, in transaction terms
    task automatic model_step();
        bit          redir, take;
        logic [31:0] tgt, w, dest;
        if (!m_started) begin
            m_started = 1;
            return;
        end
        redir = sel && m_valid;
        tgt   = pick_target(seltype);
        take  = !if_stall && (m_held || imem_ready);
        w     = m_held ? m_held_word : imem_rdata;
        if (take) begin
            dest = redir ? tgt : (m_pend ? m_pend_tgt : m_pc + 32'd4);
            if (redir || m_pend) m_redir = m_redir + 1;
            m_instr = w; m_nextpc = m_pc + 32'd4; m_valid = 1;
            m_pc = dest; m_pend = 0; m_held = 0;
        end else begin
            if (redir) begin
                m_pend = 1; m_pend_tgt = tgt;
            end
            if (!m_held && imem_ready && if_stall) begin
                m_held = 1; m_held_word = imem_rdata;
            end
            if (!m_held && !imem_ready && !if_stall) begin
                m_instr = 32'h0; m_valid = 0; m_bub = m_bub + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        imem_ready = 0; if_stall = 0; sel = 0;
        reset = 1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 0;
        tick();
    endtask

    task automatic test_reset();
        model_reset();
        @(posedge clock);
        #1;
        tests++; if (imem_read !== 1'b0) begin fails++; $display("FAIL reset_read: got %b want 0", imem_read); end
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        tests++; if (if_id_instruc !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", if_id_instruc); end
        tests++; if (if_id_nextpc !== 32'h0) begin fails++; $display("FAIL reset_nextpc: got %h want 0", if_id_nextpc); end
        reset = 0;
        tick();
        tests++; if (imem_read !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL release_fetch: got read=%b addr=%h want 1/0", imem_read, imem_addr); end
        // Mid-run async reset
        imem_ready = 1; imem_rdata = 32'h1234_5678;
        tick(); tick();
        reset = 1;
        #1;
        tests++; if (imem_read !== 1'b0 || if_id_valid !== 1'b0 || if_id_instruc !== 32'h0) begin
            fails++; $display("FAIL midrun_reset: got read=%b valid=%b instr=%h want 0/0/0", imem_read, if_id_valid, if_id_instruc);
        end
        model_reset();
        imem_ready = 0;
        @(posedge clock);
        #1;
        reset = 0;
        tick();
        tests++; if (imem_read !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL rerelease_fetch: got read=%b addr=%h want 1/0", imem_read, imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] words [3];
        words[0] = 32'hAAAA_0001; words[1] = 32'hBBBB_0002; words[2] = 32'hCCCC_0003;
        for (int i = 0; i < 3; i++) begin
            tests++; if (imem_addr !== 32'(i * 4)) begin fails++; $display("FAIL stream_addr%0d: got %h want %h", i, imem_addr, i * 4); end
            imem_ready = 1; imem_rdata = words[i];
            tick();
            tests++; if (if_id_instruc !== words[i] || if_id_nextpc !== 32'((i + 1) * 4) || if_id_valid !== 1'b1) begin
                fails++; $display("FAIL stream_out%0d: got %h/%h/%b want %h/%h/1", i, if_id_instruc, if_id_nextpc, if_id_valid, words[i], (i + 1) * 4);
            end
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        imem_ready = 1; imem_rdata = 32'h1111_0000; tick();
        imem_rdata = 32'h2222_0000; tick();
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (imem_addr !== 32'h8 || if_id_valid !== 1'b0 || if_id_instruc !== 32'h0) begin
                fails++; $display("FAIL bubble%0d: got addr=%h valid=%b instr=%h want 8/0/0", i, imem_addr, if_id_valid, if_id_instruc);
            end
        end
    endtask

    task automatic test_branch();
        imem_ready = 1; imem_rdata = 32'h1000_000F; tick();
        tests++; if (if_id_nextpc !== 32'hC || if_id_valid !== 1'b1) begin fails++; $display("FAIL branch_accept: got %h/%b want c/1", if_id_nextpc, if_id_valid); end
        sel = 1; seltype = 2'b00; pcimd2ext = 32'h40; imem_rdata = 32'h5107_0000;
        tick();
        sel = 0;
        tests++; if (if_id_instruc !== 32'h5107_0000 || if_id_nextpc !== 32'h10) begin fails++; $display("FAIL branch_slot: got %h/%h want 51070000/10", if_id_instruc, if_id_nextpc); end
        tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL branch_target: got %h want 40", imem_addr); end
    endtask

    task automatic test_jr_pend();
        imem_ready = 1; imem_rdata = 32'h03E0_0008; tick();
        sel = 1; seltype = 2'b10; rega = 32'h103; imem_ready = 0;
        tick();
        tests++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h44) begin fails++; $display("FAIL jr_wait: got valid=%b addr=%h want 0/44", if_id_valid, imem_addr); end
        imem_ready = 1; imem_rdata = 32'h5107_0001;
        tick();
        sel = 0;
        tests++; if (imem_addr !== 32'h100 || if_id_nextpc !== 32'h48) begin fails++; $display("FAIL jr_pend: got addr=%h nextpc=%h want 100/48", imem_addr, if_id_nextpc); end
        tests++; if (perf_bub !== exp_bub() || perf_redir !== exp_redir()) begin
            fails++; $display("FAIL perf_directed: got %0d/%0d want %0d/%0d", perf_bub, perf_redir, exp_bub(), exp_redir());
        end
    endtask

    task automatic test_stall_hold();
        if_stall = 1; imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        tests++; if (if_id_instruc !== 32'h5107_0001 || if_id_nextpc !== 32'h48 || imem_addr !== 32'h100) begin
            fails++; $display("FAIL stall_freeze: got %h/%h/%h want 51070001/48/100", if_id_instruc, if_id_nextpc, imem_addr);
        end
        imem_ready = 0; imem_rdata = 32'h0BAD_0BAD;
        tick();
        tests++; if (if_id_instruc !== 32'h5107_0001 || imem_read !== 1'b0) begin fails++; $display("FAIL stall_hold: got %h/%b want 51070001/0", if_id_instruc, imem_read); end
        if_stall = 0;
        tick();
        tests++; if (if_id_instruc !== 32'hDEAD_BEEF || if_id_nextpc !== 32'h104 || if_id_valid !== 1'b1 || imem_addr !== 32'h104 || imem_read !== 1'b1) begin
            fails++; $display("FAIL stall_release: got %h/%h/%b/%h want deadbeef/104/1/104", if_id_instruc, if_id_nextpc, if_id_valid, imem_addr);
        end
        tick();
        tests++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h104) begin fails++; $display("FAIL stall_nodup: got %b/%h want 0/104", if_id_valid, imem_addr); end
    endtask

    task automatic test_wrap();
        imem_ready = 1; imem_rdata = 32'h0800_0000; tick();
        sel = 1; seltype = 2'b01; pcindex = 32'hFFFF_FFFF; imem_rdata = 32'h0;
        tick();
        sel = 0;
        tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_target: got %h want fffffffc", imem_addr); end
        imem_rdata = 32'h7777_7777;
        tick();
        tests++; if (if_id_nextpc !== 32'h0 || imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_add: got nextpc=%h addr=%h want 0/0", if_id_nextpc, imem_addr); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            imem_ready = ($urandom_range(0, 9) < 7);
            if_stall   = ($urandom_range(0, 4) == 0);
            sel        = ($urandom_range(0, 5) == 0);
            seltype    = 2'($urandom_range(0, 3));
            imem_rdata = $urandom;
            pcimd2ext  = $urandom;
            pcindex    = $urandom;
            rega       = $urandom;
            tick();
            tests++; if (imem_read !== (m_started && !m_held) || imem_addr !== m_pc) begin
                fails++; $display("FAIL rand_req@%0d: got %b/%h want %b/%h", n, imem_read, imem_addr, m_started && !m_held, m_pc);
            end
            tests++; if (if_id_valid !== m_valid || if_id_instruc !== m_instr || if_id_nextpc !== m_nextpc) begin
                fails++; $display("FAIL rand_ifid@%0d: got %b/%h/%h want %b/%h/%h", n, if_id_valid, if_id_instruc, if_id_nextpc, m_valid, m_instr, m_nextpc);
            end
            tests++; if (perf_bub !== exp_bub() || perf_redir !== exp_redir()) begin
                fails++; $display("FAIL rand_perf@%0d: got %0d/%0d want %0d/%0d", n, perf_bub, perf_redir, exp_bub(), exp_redir());
            end
        end
        if_stall = 0; sel = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_bubbles();
        test_branch();
        test_jr_pend();
        test_stall_hold();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
